// File: rtl/picorv32_wb8_pkg.sv
// Shared types and constants for the PicoRV32 to 8-bit Wishbone bridge.
package picorv32_wb8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0]  CTI_CLASSIC = 3'b000;
  localparam logic [1:0]  BTE_LINEAR  = 2'b00;
  localparam logic [31:0] ERR_RDATA   = 32'hFFFF_FFFF;

  // Index of the lowest set bit; an empty mask maps to lane 0.
  function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
    logic [1:0] lane;
    lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) lane = 2'(i);
    end
    return lane;
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Per-lane cycle counter; tc flags the last cycle a byte access may stay on the bus.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  assign tc = (count_q == CW'(TIMEOUT_CYCLES - 1));

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr)           count_d = '0;
    else if (en && !tc) count_d = count_q + CW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/picorv32_wb8_bridge.sv
// Splits one 32-bit PicoRV32 native request into single-byte Wishbone classic cycles.
module picorv32_wb8_bridge
  import picorv32_wb8_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RETRY_MAX      = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [7:0]        wb_dat_o,
  input  logic [7:0]        wb_dat_i,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [2:0]        wb_cti_o,
  output logic [1:0]        wb_bte_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i,
  output logic              bus_err_o
);

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  state_e            state_q, state_d;
  logic [3:0]        mask_q, mask_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              aborted_q, aborted_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              cyc_q, cyc_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [7:0]        dat_q, dat_d;
  logic              ready_q, ready_d;
  logic              bus_err_q, bus_err_d;
  logic              abort;
  logic              tmr_tc;

  // Fetch flag and the address bits above the peripheral window carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{mem_instr, mem_addr[31:ADDR_W]};

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .clr    (state_q != BUS),
    .en     (state_q == BUS),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    lane_d    = lane_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    retry_d   = retry_q;
    aborted_d = aborted_q;
    rdata_d   = rdata_q;
    abort     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d    = mem_addr[ADDR_W-1:0];
          wdata_d   = mem_wdata;
          we_d      = |mem_wstrb;
          mask_d    = (|mem_wstrb) ? mem_wstrb : 4'b1111;
          lane_d    = lowest_lane(mask_d);
          rdata_d   = '0;
          retry_d   = '0;
          aborted_d = 1'b0;
          state_d   = BUS;
        end
      end
      BUS: begin
        // A timeout ranks with err: both end the request with the error word.
        if (wb_err_i || tmr_tc) begin
          abort = 1'b1;
        end else if (wb_ack_i) begin
          if (!we_q) rdata_d[{lane_q, 3'b000} +: 8] = wb_dat_i;
          mask_d  = mask_q & ~(4'b0001 << lane_q);
          retry_d = '0;
          state_d = (mask_d == 4'b0000) ? DONE : GAP;
        end else if (wb_rty_i) begin
          if (retry_q == RW'(RETRY_MAX)) begin
            abort = 1'b1;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = GAP;
          end
        end
        if (abort) begin
          rdata_d   = ERR_RDATA;
          aborted_d = 1'b1;
          state_d   = DONE;
        end
      end
      GAP: begin
        // A retried lane is still set and below every pending lane, so this re-selects it.
        lane_d  = lowest_lane(mask_q);
        state_d = BUS;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    cyc_d     = (state_d == BUS);
    ready_d   = (state_d == DONE);
    bus_err_d = (state_d == DONE) && aborted_d;
    adr_d     = (addr_d & ~ADDR_W'(3)) | ADDR_W'(lane_d);
    dat_d     = wdata_d[{lane_d, 3'b000} +: 8];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      lane_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      retry_q   <= '0;
      aborted_q <= 1'b0;
      rdata_q   <= '0;
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      ready_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      lane_q    <= lane_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      retry_q   <= retry_d;
      aborted_q <= aborted_d;
      rdata_q   <= rdata_d;
      cyc_q     <= cyc_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      ready_q   <= ready_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign bus_err_o = bus_err_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_cti_o  = CTI_CLASSIC;
  assign wb_bte_o  = BTE_LINEAR;

endmodule

// File: tb/tb_picorv32_wb8_bridge.sv
// Bench for picorv32_wb8_bridge: scripted slave responses, cycle timeline model, per-cycle compare.
module tb_picorv32_wb8_bridge;

  localparam int ADDR_W  = 8;
  localparam int TMO     = 16;
  localparam int RMAX    = 3;
  localparam int TL      = 512;
  localparam int NPLAN   = 32;
  localparam int K_ACK   = 0;
  localparam int K_ERR   = 1;
  localparam int K_RTY   = 2;
  localparam int K_NONE  = 3;
  localparam int K_BOTH  = 4;

  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic mem_ready, bus_err_o;
  logic [31:0] mem_rdata;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i = '0;
  logic wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0] wb_cti_o;
  logic [1:0] wb_bte_o;
  logic wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  picorv32_wb8_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO), .RETRY_MAX(RMAX)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  int cyc_idx = 0;
  always @(posedge clk) cyc_idx <= cyc_idx + 1;

  // Scripted slave: one plan entry per byte access (response kind and latency).
  int plan_kind [NPLAN];
  int plan_lat  [NPLAN];
  logic [7:0] slave_mem [256];
  int issue_n = 0;
  int cur_issue = 0;
  int hold = 0;
  bit in_issue = 0;
  bit force_ack = 0;
  logic [7:0] log_adr[$];
  logic [7:0] log_dat[$];
  logic       log_we[$];

  always @(negedge clk) begin
    if (force_ack) begin
      wb_ack_i = 1'b1; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    end else if (wb_cyc_o === 1'b1) begin
      bit resp;
      int k;
      if (!in_issue) begin
        in_issue = 1;
        hold = 0;
        cur_issue = issue_n;
        issue_n++;
        log_adr.push_back(wb_adr_o);
        log_dat.push_back(wb_dat_o);
        log_we.push_back(wb_we_o);
      end
      hold++;
      k = (cur_issue < NPLAN) ? plan_kind[cur_issue] : K_NONE;
      resp = (k != K_NONE) && (hold == plan_lat[cur_issue % NPLAN] + 1);
      wb_ack_i = resp && (k == K_ACK || k == K_BOTH);
      wb_err_i = resp && (k == K_ERR || k == K_BOTH);
      wb_rty_i = resp && (k == K_RTY);
      wb_dat_i = slave_mem[wb_adr_o];
    end else begin
      in_issue = 0;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    end
  end

  // Expected timeline of one request, indexed by cycles after the request cycle.
  logic       exp_stb [TL];
  logic [7:0] exp_adr [TL];
  logic [7:0] exp_dat [TL];
  logic       exp_we;
  logic [31:0] exp_rdata;
  logic       exp_err;
  int t_ready;

  task automatic build_model(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    int t, idx, retries, k, dur;
    bit failed, lane_done;
    logic [3:0] mask;
    logic [7:0] a;
    for (int i = 0; i < TL; i++) begin exp_stb[i] = 0; exp_adr[i] = '0; exp_dat[i] = '0; end
    exp_we = (wstrb != 0);
    mask = exp_we ? wstrb : 4'hF;
    exp_rdata = '0;
    failed = 0;
    t = 1;
    idx = 0;
    for (int lane = 0; lane < 4 && !failed; lane++) begin
      if (mask[lane]) begin
        retries = 0;
        lane_done = 0;
        a = {addr[7:2], 2'(lane)};
        while (!lane_done && !failed) begin
          if (idx > 0) t++;  // one idle cycle between any two accesses
          k = plan_kind[idx];
          dur = (k == K_NONE) ? TMO : plan_lat[idx] + 1;
          idx++;
          for (int d = 0; d < dur; d++) begin
            exp_stb[t + d] = 1;
            exp_adr[t + d] = a;
            exp_dat[t + d] = wdata[8*lane +: 8];
          end
          t += dur;
          if (k == K_ERR || k == K_BOTH || k == K_NONE) failed = 1;
          else if (k == K_ACK) begin
            if (!exp_we) exp_rdata[8*lane +: 8] = slave_mem[a];
            lane_done = 1;
          end else begin
            retries++;
            if (retries > RMAX) failed = 1;
          end
        end
      end
    end
    exp_err = failed;
    if (failed) exp_rdata = 32'hFFFF_FFFF;
    t_ready = t;
  endtask

  bit active = 0;
  bit skip = 1;
  int t0 = 0;
  int cmp_t;

  // Single compare process against the model timeline (or the idle expectation).
  always @(negedge clk) begin
    if (!skip) begin
      check("stb_eq_cyc", wb_stb_o, wb_cyc_o);
      check("cti", wb_cti_o, 3'b000);
      check("bte", wb_bte_o, 2'b00);
      if (active) begin
        cmp_t = cyc_idx - t0;
        if (cmp_t < TL) begin
          check("cyc", wb_cyc_o, exp_stb[cmp_t]);
          if (exp_stb[cmp_t]) begin
            check("adr", wb_adr_o, exp_adr[cmp_t]);
            check("dat", wb_dat_o, exp_dat[cmp_t]);
            check("we", wb_we_o, exp_we);
          end
          check("ready", mem_ready, cmp_t == t_ready);
          if (cmp_t == t_ready) begin
            check("rdata", mem_rdata, exp_rdata);
            check("bus_err", bus_err_o, exp_err);
          end else begin
            check("bus_err_idle", bus_err_o, 1'b0);
          end
        end
      end else begin
        check("idle_cyc", wb_cyc_o, 1'b0);
        check("idle_ready", mem_ready, 1'b0);
        check("idle_bus_err", bus_err_o, 1'b0);
      end
    end
  end

  int got_t;
  logic [31:0] got_rdata;
  logic got_err;

  task automatic start_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    @(posedge clk); #2;
    build_model(addr, wdata, wstrb);
    issue_n = 0;
    log_adr.delete(); log_dat.delete(); log_we.delete();
    t0 = cyc_idx;
    active = 1;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    mem_instr = $urandom_range(0, 1);
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    int n;
    start_req(addr, wdata, wstrb);
    n = 0;
    do begin @(negedge clk); n++; end while (mem_ready !== 1'b1 && n < 600);
    check("ready_seen", mem_ready, 1'b1);
    got_t = cyc_idx - t0;
    got_rdata = mem_rdata;
    got_err = bus_err_o;
    @(posedge clk); #2;  // mem_valid stays high through DONE and drops afterwards
    mem_valid = 1'b0; mem_wstrb = '0;
    active = 0;
  endtask

  task automatic plan_all_ack(input int lat);
    for (int i = 0; i < NPLAN; i++) begin plan_kind[i] = K_ACK; plan_lat[i] = lat; end
  endtask

  task automatic plan_random();
    int r;
    for (int i = 0; i < NPLAN; i++) begin
      r = $urandom_range(0, 99);
      plan_lat[i] = $urandom_range(1, 4);
      if (r < 70)      plan_kind[i] = K_ACK;
      else if (r < 84) plan_kind[i] = K_RTY;
      else if (r < 92) plan_kind[i] = K_ERR;
      else if (r < 97) plan_kind[i] = K_BOTH;
      else             plan_kind[i] = K_NONE;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'($urandom);
    plan_all_ack(1);

    repeat (3) @(posedge clk);
    #2 i_reset = 1'b0;
    @(negedge clk);
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_we", wb_we_o, 1'b0);
    check("rst_ready", mem_ready, 1'b0);
    check("rst_bus_err", bus_err_o, 1'b0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_adr", wb_adr_o, 8'h00);
    check("rst_dat", wb_dat_o, 8'h00);
    skip = 0;

    // Full read, ack latency 1.
    slave_mem[8'h10] = 8'h11; slave_mem[8'h11] = 8'h22;
    slave_mem[8'h12] = 8'h33; slave_mem[8'h13] = 8'h44;
    do_req(32'h0000_0010, 32'h0, 4'b0000);
    check("read_rdata_lit", got_rdata, 32'h4433_2211);
    check("read_latency_lit", got_t, 12);
    check("read_err_lit", got_err, 1'b0);
    check("read_issues_lit", log_adr.size(), 4);

    // Sparse write touches only lanes 1 and 3.
    do_req(32'h0000_0020, 32'hAABB_CCDD, 4'b1010);
    check("wr_latency_lit", got_t, 6);
    check("wr_issues_lit", log_adr.size(), 2);
    if (log_adr.size() == 2) begin
      check("wr_adr0_lit", log_adr[0], 8'h21);
      check("wr_dat0_lit", log_dat[0], 8'hCC);
      check("wr_adr1_lit", log_adr[1], 8'h23);
      check("wr_dat1_lit", log_dat[1], 8'hAA);
      check("wr_we_lit", log_we[0], 1'b1);
    end
    check("wr_rdata_lit", got_rdata, 32'h0);

    // Silent slave: timeout after 16 strobe cycles, then a normal read.
    plan_kind[0] = K_NONE;
    do_req(32'h0000_0030, 32'h0, 4'b0000);
    check("tmo_latency_lit", got_t, 17);
    check("tmo_rdata_lit", got_rdata, 32'hFFFF_FFFF);
    check("tmo_err_lit", got_err, 1'b1);
    plan_all_ack(1);
    do_req(32'h0000_0010, 32'h0, 4'b0000);
    check("after_tmo_rdata_lit", got_rdata, 32'h4433_2211);

    // Two retries then ack on lane 0.
    plan_all_ack(1);
    plan_kind[0] = K_RTY; plan_kind[1] = K_RTY;
    do_req(32'h0000_0010, 32'h0, 4'b0000);
    check("rty2_issues_lit", log_adr.size(), 6);
    check("rty2_err_lit", got_err, 1'b0);
    check("rty2_rdata_lit", got_rdata, 32'h4433_2211);

    // Four retries exceed the limit.
    for (int i = 0; i < 4; i++) plan_kind[i] = K_RTY;
    do_req(32'h0000_0010, 32'h0, 4'b0000);
    check("rty4_err_lit", got_err, 1'b1);
    check("rty4_issues_lit", log_adr.size(), 4);
    check("rty4_latency_lit", got_t, 12);

    // ack and err together: err wins.
    plan_all_ack(1);
    plan_kind[1] = K_BOTH;
    do_req(32'h0000_0010, 32'h0, 4'b0000);
    check("both_err_lit", got_err, 1'b1);
    check("both_rdata_lit", got_rdata, 32'hFFFF_FFFF);

    // Stray ack while idle must not complete anything.
    @(posedge clk); #2 force_ack = 1;
    repeat (5) @(posedge clk);
    #2 force_ack = 0;
    repeat (2) @(posedge clk);

    // Reset during lane 2 of a read.
    plan_all_ack(1);
    plan_lat[2] = 3;
    start_req(32'h0000_0040, 32'h0, 4'b0000);
    while ((cyc_idx - t0) < 7) @(negedge clk);
    @(posedge clk); #2;
    active = 0; skip = 1; i_reset = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #2;
    i_reset = 1'b0;
    @(negedge clk);
    check("mid_rst_cyc", wb_cyc_o, 1'b0);
    check("mid_rst_ready", mem_ready, 1'b0);
    check("mid_rst_rdata", mem_rdata, 32'h0);
    skip = 0;
    repeat (3) @(posedge clk);
    plan_all_ack(2);
    do_req(32'h0000_0010, 32'h0, 4'b0000);
    check("after_rst_rdata_lit", got_rdata, 32'h4433_2211);
    check("after_rst_err_lit", got_err, 1'b0);

    // Randomized requests and slave behaviour.
    for (int n = 0; n < 40; n++) begin
      plan_random();
      do_req($urandom, $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
